// File: rtl/multiplier_pipelined_param.sv
// multiplier_pipelined_param: limb-split pipelined multiplier with valid/ready flow control.
// Define MUL_SIGNED_EN to honour is_signed (two's-complement mode); otherwise every product is unsigned.
module multiplier_pipelined_param #(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = 11,
    parameter int STAGES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
);
    localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW = N * CHUNK;
    localparam int PP = 2 * CHUNK;
    localparam int CW = PP + $clog2(N);
    localparam int NC = 2 * N - 1;
    localparam int RW = 2 * WIDTH;
    localparam int D  = STAGES - 2;

    logic          stall, ld1, ld2, ld3;
    logic [PW-1:0] ax, bx;
    logic [RW-1:0] acc, res;
    logic          v1_d, v1_q, v2_d, v2_q;
    logic [PP-1:0] pp_d [N*N];
    logic [PP-1:0] pp_q [N*N];
    logic [CW-1:0] col_s [NC];
    logic [CW-1:0] col_d [NC];
    logic [CW-1:0] col_q [NC];
    logic [RW-1:0] dr_d [D];
    logic [RW-1:0] dr_q [D];
    logic          dv_d [D];
    logic          dv_q [D];
`ifdef MUL_SIGNED_EN
    logic [WIDTH-1:0] na, nb;
    logic             neg1_d, neg1_q, neg2_d, neg2_q;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    assign out_valid = dv_q[D-1];
    assign r         = dr_q[D-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign ld1       = in_ready && in_valid;
    assign ld2       = in_ready && v1_q;
    assign ld3       = in_ready && v2_q;

    always_comb begin
        ax = PW'(a);
        bx = PW'(b);
`ifdef MUL_SIGNED_EN
        na = -a;
        nb = -b;
        if (is_signed && a[WIDTH-1]) ax = PW'(na);
        if (is_signed && b[WIDTH-1]) bx = PW'(nb);
        neg1_d = ld1 ? is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) : neg1_q;
        neg2_d = ld2 ? neg1_q : neg2_q;
`endif
        v1_d = stall ? v1_q : in_valid;
        v2_d = stall ? v2_q : v1_q;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                pp_d[i*N+j] = ld1 ? PP'(ax[i*CHUNK +: CHUNK]) * PP'(bx[j*CHUNK +: CHUNK]) : pp_q[i*N+j];
        for (int k = 0; k < NC; k++) col_s[k] = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                col_s[i+j] = col_s[i+j] + CW'(pp_q[i*N+j]);
        for (int k = 0; k < NC; k++) col_d[k] = ld2 ? col_s[k] : col_q[k];
        // Columns overlap by CHUNK bits; the RW-bit accumulator truncates the carry-out modulo 2^RW.
        acc = '0;
        for (int k = 0; k < NC; k++) acc = acc + (RW'(col_q[k]) << (k * CHUNK));
`ifdef MUL_SIGNED_EN
        res = neg2_q ? -acc : acc;
`else
        res = acc;
`endif
        dv_d[0] = stall ? dv_q[0] : v2_q;
        dr_d[0] = ld3 ? res : dr_q[0];
        for (int k = 1; k < D; k++) begin
            dv_d[k] = stall ? dv_q[k] : dv_q[k-1];
            dr_d[k] = (in_ready && dv_q[k-1]) ? dr_q[k-1] : dr_q[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int k = 0; k < N*N; k++) pp_q[k] <= '0;
            for (int k = 0; k < NC; k++) col_q[k] <= '0;
            for (int k = 0; k < D; k++) begin
                dv_q[k] <= 1'b0;
                dr_q[k] <= '0;
            end
`ifdef MUL_SIGNED_EN
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
`endif
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            for (int k = 0; k < N*N; k++) pp_q[k] <= pp_d[k];
            for (int k = 0; k < NC; k++) col_q[k] <= col_d[k];
            for (int k = 0; k < D; k++) begin
                dv_q[k] <= dv_d[k];
                dr_q[k] <= dr_d[k];
            end
`ifdef MUL_SIGNED_EN
            neg1_q <= neg1_d;
            neg2_q <= neg2_d;
`endif
        end
    end
endmodule

// File: tb/tb_multiplier_pipelined_param.sv
// tb_multiplier_pipelined_param: directed vectors, streaming, backpressure and mid-flight reset.
// Expected values follow MUL_SIGNED_EN: signed results when defined, unsigned otherwise.
module tb_multiplier_pipelined_param;
`ifdef MUL_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif
    localparam int STG = 3;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [63:0] es;
        logic [63:0] eu;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [31:0] a, b;
    logic [63:0] r;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    vec_t        vecs [10];

    multiplier_pipelined_param #(.WIDTH(32), .CHUNK(11), .STAGES(STG)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .r(r)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        if (s && SEN) return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic single(input string nm, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [63:0] e);
        int lat;
        @(negedge clk);
        a = x; b = y; is_signed = s; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(STG));
        chk(nm, r, e);
    endtask

    task automatic run_stream(input string nm, input int n, input int st, input int sl);
        logic [63:0] q [$];
        logic [63:0] held = '0;
        int sent = 0, got = 0, cyc = 0;
        bit acc = 1'b1, hv = 1'b0;
        while (got < n && cyc < n + 60) begin
            @(negedge clk);
            if (acc) begin
                a = $urandom;
                b = $urandom;
                is_signed = $urandom_range(0, 1) != 0;
            end
            out_ready = !(cyc >= st && cyc < st + sl);
            in_valid = sent < n;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL %s_extra: got unexpected product %0h, expected none", nm, r);
                end else chk({nm, "_data"}, r, q.pop_front());
                got++;
            end
            if (out_valid && !out_ready) begin
                chk({nm, "_stall_rdy"}, 64'(in_ready), 64'd0);
                if (hv) chk({nm, "_hold"}, r, held);
                held = r;
                hv = 1'b1;
            end else hv = 1'b0;
            if (sl == 0 && in_valid) chk({nm, "_rdy"}, 64'(in_ready), 64'd1);
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(a, b, is_signed));
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk({nm, "_count"}, 64'(got), 64'(n));
        chk({nm, "_left"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001};
        vecs[1] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 64'h4000000000000000};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFF9, 64'h00000006FFFFFFF9};
        vecs[3] = '{32'h00000000, 32'h12345678, 1'b1, 64'h0000000000000000, 64'h0000000000000000};
        vecs[4] = '{32'h00000003, 32'h00000005, 1'b0, 64'h000000000000000F, 64'h000000000000000F};
        vecs[5] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA, 64'h00000002FFFFFFFA};
        vecs[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001, 64'h3FFFFFFF00000001};
        vecs[7] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, 64'h0000000080000000};
        vecs[8] = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 64'h0000000100000000};
        vecs[9] = '{32'h00000064, 32'hFFFFFF9C, 1'b1, 64'hFFFFFFFFFFFFD8F0, 64'h00000063FFFFD8F0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; is_signed = 1'b0; a = '0; b = '0;
        @(negedge clk);
        chk("reset_ov", 64'(out_valid), 64'd0);
        chk("reset_r", r, 64'd0);
        chk("reset_rdy", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ov", 64'(out_valid), 64'd0);

        for (int i = 0; i < 10; i++)
            single($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].s, SEN ? vecs[i].es : vecs[i].eu);

        run_stream("stream", 100, 1000, 0);
        run_stream("bp", 20, 8, 4);

        @(negedge clk);
        a = 32'd5; b = 32'd6; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 32'd7; b = 32'd8;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_ov", 64'(out_valid), 64'd0);
        chk("midrst_r", r, 64'd0);
        chk("midrst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("postrst_ov%0d", i), 64'(out_valid), 64'd0);
        end
        single("postrst_op", 32'd9, 32'd11, 1'b0, 64'd99);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
